uart_cmd_loader: RTL and testbench

UART_CMD_LOADER -- requirements
Module: uart_cmd_loader

---
 rtl/uart_cmd_loader.sv | 152 +++++++++++++++
 tb/tb_uart_cmd_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_loader.sv
// UART command loader: byte-level single-step/run/halt commands and framed instruction-memory loads.
// Optional checksum byte after the data bytes when UART_CMD_LOADER_CHECKSUM_EN is defined.
module uart_cmd_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_rdy,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wr_data,
  output logic              step_pulse,
  output logic              dump_req,
  output logic              run_en,
  output logic              busy,
  output logic              load_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef UART_CMD_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, GET_COUNT, GET_DATA, GET_CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, GET_COUNT, GET_DATA} state_t;
`endif

  state_t        state;
  logic          rdy_q;
  logic [TW-1:0] idle_cnt;
  logic [8:0]    words_left;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
`ifdef UART_CMD_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  logic accept;
  logic timeout;

  // rdy_q resets high so a level already present at reset release is not a byte
  assign accept  = rx_data_rdy & ~rdy_q;
  assign timeout = (state != IDLE) && (idle_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rdy_q        <= 1'b1;
      idle_cnt     <= '0;
      words_left   <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      imem_wr_en   <= 1'b0;
      imem_addr    <= '0;
      imem_wr_data <= '0;
      step_pulse   <= 1'b0;
      dump_req     <= 1'b0;
      run_en       <= 1'b0;
      busy         <= 1'b0;
      load_err     <= 1'b0;
`ifdef UART_CMD_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      rdy_q      <= rx_data_rdy;
      imem_wr_en <= 1'b0;
      step_pulse <= 1'b0;
      dump_req   <= 1'b0;

      // Address advances after the strobe cycle so it is stable while the strobe is high
      if (imem_wr_en)
        imem_addr <= imem_addr + 1'b1;

      if (state == IDLE || accept)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      if (timeout) begin
        // Partial word is dropped; a byte arriving this very cycle is ignored too
        state    <= IDLE;
        busy     <= 1'b0;
        load_err <= 1'b1;
        byte_idx <= '0;
      end else if (accept) begin
        case (state)
          IDLE: begin
            case (rx_data)
              8'h41: begin
                step_pulse <= 1'b1;
                dump_req   <= 1'b1;
              end
              8'h52: run_en <= 1'b1;
              8'h48: run_en <= 1'b0;
              8'h4C: begin
                run_en    <= 1'b0;
                load_err  <= 1'b0;
                imem_addr <= '0;
                byte_idx  <= '0;
                state     <= GET_COUNT;
                busy      <= 1'b1;
`ifdef UART_CMD_LOADER_CHECKSUM_EN
                csum      <= '0;
`endif
              end
              default: ;
            endcase
          end
          GET_COUNT: begin
            words_left <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            state      <= GET_DATA;
          end
          GET_DATA: begin
`ifdef UART_CMD_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_wr_en   <= 1'b1;
              imem_wr_data <= {rx_data, word_buf};
              words_left   <= words_left - 9'd1;
              if (words_left == 9'd1) begin
`ifdef UART_CMD_LOADER_CHECKSUM_EN
                state <= GET_CSUM;
`else
                state <= IDLE;
                busy  <= 1'b0;
`endif
              end
            end else begin
              word_buf <= {rx_data, word_buf[23:8]};
            end
          end
`ifdef UART_CMD_LOADER_CHECKSUM_EN
          GET_CSUM: begin
            if (rx_data != csum)
              load_err <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
`endif
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Directed bench for uart_cmd_loader: byte table plus hold, timeout, reset and checksum sequences.
module tb_uart_cmd_loader;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 20;
`ifdef UART_CMD_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_data_rdy = 1'b0;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wr_data;
  logic              step_pulse, dump_req, run_en, busy, load_err;

  uart_cmd_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
    .imem_wr_en(imem_wr_en), .imem_addr(imem_addr), .imem_wr_data(imem_wr_data),
    .step_pulse(step_pulse), .dump_req(dump_req), .run_en(run_en),
    .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        step;
    logic        run;
    logic        bsy;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   wr_cnt = 0, step_cnt = 0, dump_cnt = 0;
  logic prev_wr = 1'b0, dbl = 1'b0;

  // Snapshot taken one cycle after the byte is presented
  logic        s_wr, s_step, s_dump, s_run, s_busy, s_err;
  logic [7:0]  s_addr;
  logic [31:0] s_data;

  always @(negedge clk) begin
    if (imem_wr_en) wr_cnt++;
    if (step_pulse) step_cnt++;
    if (dump_req) dump_cnt++;
    if (imem_wr_en && prev_wr) dbl = 1'b1;
    prev_wr = imem_wr_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic wr, input logic [7:0] addr,
                     input logic [31:0] data, input logic step, input logic run,
                     input logic bsy, input logic err);
    vec_t v;
    v.b = b; v.wr = wr; v.addr = addr; v.data = data;
    v.step = step; v.run = run; v.bsy = bsy; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_data_rdy = 1'b1;
    @(negedge clk);
    s_wr = imem_wr_en; s_addr = imem_addr; s_data = imem_wr_data;
    s_step = step_pulse; s_dump = dump_req; s_run = run_en;
    s_busy = busy; s_err = load_err;
    rx_data_rdy = 1'b0;
    @(negedge clk);
  endtask

  int wr0, st0;

  initial begin
    // Two-word frame, commands, run cleared by 'L', one-word frame, ignored byte
    add(8'h4C, 0, 0, 0, 0, 0, 1, 0);
    add(8'h02, 0, 0, 0, 0, 0, 1, 0);
    add(8'h78, 0, 0, 0, 0, 0, 1, 0);
    add(8'h56, 0, 0, 0, 0, 0, 1, 0);
    add(8'h34, 0, 0, 0, 0, 0, 1, 0);
    add(8'h12, 1, 0, 32'h12345678, 0, 0, 1, 0);
    add(8'hEF, 0, 0, 0, 0, 0, 1, 0);
    add(8'hBE, 0, 0, 0, 0, 0, 1, 0);
    add(8'hAD, 0, 0, 0, 0, 0, 1, 0);
    add(8'hDE, 1, 1, 32'hDEADBEEF, 0, 0, CS, 0);
    if (CS) add(8'h2A, 0, 0, 0, 0, 0, 0, 0);
    add(8'h52, 0, 0, 0, 0, 1, 0, 0);
    add(8'h41, 0, 0, 0, 1, 1, 0, 0);
    add(8'h48, 0, 0, 0, 0, 0, 0, 0);
    add(8'h52, 0, 0, 0, 0, 1, 0, 0);
    add(8'h4C, 0, 0, 0, 0, 0, 1, 0);
    add(8'h01, 0, 0, 0, 0, 0, 1, 0);
    add(8'h11, 0, 0, 0, 0, 0, 1, 0);
    add(8'h22, 0, 0, 0, 0, 0, 1, 0);
    add(8'h33, 0, 0, 0, 0, 0, 1, 0);
    add(8'h44, 1, 0, 32'h44332211, 0, 0, CS, 0);
    if (CS) add(8'h44, 0, 0, 0, 0, 0, 0, 0);
    add(8'h58, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst_wr_en", imem_wr_en, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_data", imem_wr_data, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_dump", dump_req, 0);
    chk("rst_run", run_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", load_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      send(vecs[i].b);
      chk($sformatf("v%0d_wr", i), s_wr, vecs[i].wr);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_addr", i), s_addr, vecs[i].addr);
        chk($sformatf("v%0d_data", i), s_data, vecs[i].data);
      end
      chk($sformatf("v%0d_step", i), s_step, vecs[i].step);
      chk($sformatf("v%0d_dump", i), s_dump, vecs[i].step);
      chk($sformatf("v%0d_run", i), s_run, vecs[i].run);
      chk($sformatf("v%0d_busy", i), s_busy, vecs[i].bsy);
      chk($sformatf("v%0d_err", i), s_err, vecs[i].err);
    end
    chk("table_writes", wr_cnt, 3);

    // Held 'A' level counts as one byte
    st0 = step_cnt;
    @(negedge clk);
    rx_data = 8'h41;
    rx_data_rdy = 1'b1;
    repeat (10) @(negedge clk);
    rx_data_rdy = 1'b0;
    @(negedge clk);
    chk("hold_step_count", step_cnt - st0, 1);
    chk("hold_dump_count", dump_cnt - st0, 1);

    // Timeout mid-word: no write, error set, back to idle
    wr0 = wr_cnt;
    send(8'h4C); send(8'h01); send(8'h11); send(8'h22);
    repeat (TIMEOUT / 2) @(negedge clk);
    chk("tmo_busy_before", busy, 1);
    chk("tmo_err_before", load_err, 0);
    repeat (TIMEOUT) @(negedge clk);
    chk("tmo_busy_after", busy, 0);
    chk("tmo_err_after", load_err, 1);
    chk("tmo_no_write", wr_cnt - wr0, 0);
    send(8'h4C);
    chk("tmo_err_cleared_by_L", s_err, 0);
    send(8'h00);

    // Reset mid-frame, with the ready level high across reset release
    wr0 = wr_cnt;
    st0 = step_cnt;
    rst_n = 1'b0;
    rx_data = 8'h41;
    rx_data_rdy = 1'b1;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_addr", imem_addr, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_no_step_held", step_cnt - st0, 0);
    chk("mrst_no_write", wr_cnt - wr0, 0);
    rx_data_rdy = 1'b0;
    @(negedge clk);
    send(8'h4C); send(8'h01); send(8'h04); send(8'h03); send(8'h02); send(8'h01);
    chk("mrst_frame_wr", s_wr, 1);
    chk("mrst_frame_addr", s_addr, 0);
    chk("mrst_frame_data", s_data, 32'h01020304);
    if (CS) send(8'h04);
    chk("mrst_frame_busy", busy, 0);

`ifdef UART_CMD_LOADER_CHECKSUM_EN
    send(8'h4C); send(8'h01); send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    chk("cs_good_wr", s_wr, 1);
    chk("cs_good_data", s_data, 32'h08040201);
    send(8'h0F);
    chk("cs_good_err", s_err, 0);
    chk("cs_good_busy", s_busy, 0);
    send(8'h4C); send(8'h01); send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    chk("cs_bad_wr", s_wr, 1);
    send(8'h00);
    chk("cs_bad_err", s_err, 1);
    chk("cs_bad_busy", s_busy, 0);
`endif

    chk("no_double_strobe", dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end
endmodule
